// File: rtl/irig_b_pkg.sv
// -----------------------------------------------------------------------------
// irig_b_pkg
// Shared definitions for the IRIG-B time input: symbol codes from the pulse
// classifier, frame geometry, BCD field slot positions, the frame controller
// state encoding and the packed layout of the assembled time word.
// No ports (package).
// -----------------------------------------------------------------------------
package irig_b_pkg;

  // Symbol codes produced by the pulse classifier (one-hot)
  localparam logic [2:0] IRIG_L = 3'b001;  // logic 0
  localparam logic [2:0] IRIG_P = 3'b010;  // position identifier / reference marker
  localparam logic [2:0] IRIG_H = 3'b100;  // logic 1

  // Frame geometry
  localparam int FRAME_LEN = 100;
  localparam int IDX_W     = 7;
  localparam int LAST_IDX  = FRAME_LEN - 1;

  // BCD field slots: first/last symbol index of each digit, LSB first.
  // Order: sec units, sec tens, min units, min tens, hour units, hour tens,
  //        day units, day tens, day hundreds, year units, year tens.
  localparam int NUM_FLD = 11;
  localparam int FLD_LO [NUM_FLD] = '{ 1,  6, 10, 15, 20, 25, 30, 35, 40, 50, 55};
  localparam int FLD_HI [NUM_FLD] = '{ 4,  8, 13, 17, 23, 26, 33, 38, 41, 53, 58};
  // Bit offset of each digit inside time_bcd_t (sec occupies the LSBs)
  localparam int FLD_BASE [NUM_FLD] = '{ 0,  4,  7, 11, 14, 18, 20, 24, 28, 30, 34};

  // Frame controller states
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,  // waiting for any P
    ST_ARM  = 2'd1,  // one P seen, next P is Pr
    ST_RECV = 2'd2   // receiving symbols 1..99 then Pr
  } state_t;

  // Assembled time word, each field laid out exactly like its output port
  typedef struct packed {
    logic [7:0] year;  // {tens[3:0], units[3:0]}
    logic [9:0] day;   // {hund[1:0], tens[3:0], units[3:0]}
    logic [5:0] hour;  // {tens[1:0], units[3:0]}
    logic [6:0] min;   // {tens[2:0], units[3:0]}
    logic [6:0] sec;   // {tens[2:0], units[3:0]}
  } time_bcd_t;

  localparam int TIME_W = $bits(time_bcd_t);
  localparam int POS_W  = $clog2(TIME_W);

  typedef struct packed {
    logic             hit;  // slot carries a BCD bit
    logic [POS_W-1:0] pos;  // bit position inside time_bcd_t
  } slot_map_t;

  // Map a symbol index onto its bit of the time word, if it has one
  function automatic slot_map_t map_slot(input logic [IDX_W-1:0] idx);
    slot_map_t m;
    m = '0;
    for (int f = 0; f < NUM_FLD; f++) begin
      if (int'(idx) >= FLD_LO[f] && int'(idx) <= FLD_HI[f]) begin
        m.hit = 1'b1;
        m.pos = POS_W'(FLD_BASE[f] + int'(idx) - FLD_LO[f]);
      end
    end
    return m;
  endfunction

  // Pr (index 0) and P1..P9, P0 at indices 9, 19, ..., 99
  function automatic logic is_marker_slot(input logic [IDX_W-1:0] idx);
    return (idx == '0) || ((idx % 7'd10) == 7'd9);
  endfunction

endpackage

// File: rtl/irig_b_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// irig_b_frame_ctrl_if
// Bundle between the pulse classifier / time consumers and the IRIG-B frame
// controller.
//   Plus_type[2:0], Ready        : classified symbol and its 1-cycle strobe
//   sec/min/hour/day/year_bcd    : last published BCD time
//   frame_valid, frame_start,
//   frame_err, timeout           : 1-cycle event strobes
//   locked                       : level, time fields trustworthy
// Modports: master = classifier/consumer side, slave = frame controller.
// -----------------------------------------------------------------------------
interface irig_b_frame_ctrl_if;
  logic [2:0] Plus_type;
  logic       Ready;
  logic [6:0] sec_bcd;
  logic [6:0] min_bcd;
  logic [5:0] hour_bcd;
  logic [9:0] day_bcd;
  logic [7:0] year_bcd;
  logic       frame_valid;
  logic       frame_start;
  logic       frame_err;
  logic       timeout;
  logic       locked;

  modport master (
    output Plus_type, Ready,
    input  sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd,
    input  frame_valid, frame_start, frame_err, timeout, locked
  );

  modport slave (
    input  Plus_type, Ready,
    output sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd,
    output frame_valid, frame_start, frame_err, timeout, locked
  );
endinterface

// File: rtl/irig_b_bcd_check.sv
// -----------------------------------------------------------------------------
// irig_b_bcd_check
// Combinational plausibility check of an assembled IRIG-B time word.
// Every units/tens digit must be a decimal digit, and the values must be in
// range: sec <= 59, min <= 59, hour <= 23, day of year 1..366.
// Ports:
//   fields  in  time_bcd_t : BCD time word to check
//   bcd_ok  out 1          : 1 when every digit and range check holds
// -----------------------------------------------------------------------------
module irig_b_bcd_check
  import irig_b_pkg::*;
(
  input  time_bcd_t fields,
  output logic      bcd_ok
);

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  logic [3:0] sec_u, min_u, hour_u, day_u, day_t, year_u, year_t;
  logic [2:0] sec_t, min_t;
  logic [5:0] hour_bin;
  logic [9:0] day_bin;
  logic       digits_ok, sec_ok, min_ok, hour_ok, day_ok;

  always_comb begin
    sec_u  = fields.sec[3:0];
    sec_t  = fields.sec[6:4];
    min_u  = fields.min[3:0];
    min_t  = fields.min[6:4];
    hour_u = fields.hour[3:0];
    day_u  = fields.day[3:0];
    day_t  = fields.day[7:4];
    year_u = fields.year[3:0];
    year_t = fields.year[7:4];

    // 2- and 3-bit tens digits can never exceed 9 on their own
    digits_ok = (sec_u  <= DIGIT_MAX) && (min_u  <= DIGIT_MAX) &&
                (hour_u <= DIGIT_MAX) && (day_u  <= DIGIT_MAX) &&
                (day_t  <= DIGIT_MAX) && (year_u <= DIGIT_MAX) &&
                (year_t <= DIGIT_MAX);

    // Binary values for the ranges that do not fall on a digit boundary
    hour_bin = 6'(fields.hour[5:4]) * 6'd10 + 6'(hour_u);
    day_bin  = 10'(fields.day[9:8]) * 10'd100 + 10'(day_t) * 10'd10 + 10'(day_u);

    sec_ok  = (sec_t <= 3'd5);
    min_ok  = (min_t <= 3'd5);
    hour_ok = (hour_bin <= 6'd23);
    day_ok  = (day_bin >= 10'd1) && (day_bin <= 10'd366);

    bcd_ok = digits_ok && sec_ok && min_ok && hour_ok && day_ok;
  end

endmodule

// File: rtl/irig_b_frame_ctrl.sv
// -----------------------------------------------------------------------------
// irig_b_frame_ctrl
// IRIG-B frame-level controller. Locks onto the 100-symbol frame using the
// double-P reference marker, checks every position-identifier slot, assembles
// the BCD time fields into a shadow word and publishes it once per frame after
// a digit/range check. A watchdog drops lock when symbols stop arriving.
// Ports:
//   Clk    in  1  : system clock (125 MHz)
//   Rst_n  in  1  : asynchronous active-low reset
//   bus    slave  : Plus_type/Ready in; BCD time, frame_valid, frame_start,
//                   frame_err, timeout (1-cycle strobes) and locked out
// Parameter:
//   TIMEOUT_CYC : Clk cycles without Ready before the stream is declared lost
// -----------------------------------------------------------------------------
module irig_b_frame_ctrl
  import irig_b_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_500_000
)(
  input logic             Clk,
  input logic             Rst_n,
  irig_b_frame_ctrl_if.slave bus
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  // Next-state / next-output values (combinational)
  state_t           state_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             locked_p0, start_p0, vld_p0, err_p0, tmo_p0;
  logic [WD_W-1:0]  wd_p0;
  logic             pub_en_p0, cap_en_p0, cap_bit_p0;
  logic             frame_bad_p0, wd_expire_p0, is_p_p0, is_data_p0;
  slot_map_t        slot_p0;

  // Registered state and outputs
  state_t           state_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             locked_p1, start_p1, vld_p1, err_p1, tmo_p1;
  logic [WD_W-1:0]  wd_p1;
  time_bcd_t        time_p1;
  logic [TIME_W-1:0] shadow_p1;

  logic             bcd_ok;

  irig_b_bcd_check u_bcd_check (
    .fields (time_bcd_t'(shadow_p1)),
    .bcd_ok (bcd_ok)
  );

  // ---- stage p0: symbol decode, frame FSM and watchdog next-state ----
  always_comb begin
    state_p0     = state_p1;
    idx_p0       = idx_p1;
    locked_p0    = locked_p1;
    start_p0     = 1'b0;
    vld_p0       = 1'b0;
    err_p0       = 1'b0;
    tmo_p0       = 1'b0;
    pub_en_p0    = 1'b0;
    cap_en_p0    = 1'b0;
    frame_bad_p0 = 1'b0;
    wd_p0        = wd_p1 + 1'b1;
    slot_p0      = map_slot(idx_p1);
    is_p_p0      = (bus.Plus_type == IRIG_P);
    is_data_p0   = (bus.Plus_type == IRIG_L) || (bus.Plus_type == IRIG_H);
    cap_bit_p0   = (bus.Plus_type == IRIG_H);
    // A symbol arriving on the expiry cycle keeps the stream alive
    wd_expire_p0 = !bus.Ready && (wd_p1 == WD_LAST);

    if (bus.Ready) begin
      wd_p0 = '0;
      case (state_p1)
        ST_HUNT: begin
          if (is_p_p0) state_p0 = ST_ARM;
        end
        ST_ARM: begin
          // Second consecutive P is Pr; anything else just restarts the hunt
          if (is_p_p0) begin
            start_p0 = 1'b1;
            idx_p0   = 7'd1;
            state_p0 = ST_RECV;
          end else begin
            state_p0 = ST_HUNT;
          end
        end
        ST_RECV: begin
          if (is_marker_slot(idx_p1)) begin
            if (!is_p_p0) begin
              frame_bad_p0 = 1'b1;
            end else if (idx_p1 == '0) begin
              start_p0 = 1'b1;
              idx_p0   = 7'd1;
            end else if (idx_p1 == IDX_W'(LAST_IDX)) begin
              // Every field bit was rewritten during this frame, so the
              // shadow holds only this frame's data when it is published
              if (bcd_ok) begin
                pub_en_p0 = 1'b1;
                vld_p0    = 1'b1;
                locked_p0 = 1'b1;
                idx_p0    = '0;
              end else begin
                frame_bad_p0 = 1'b1;
              end
            end else begin
              idx_p0 = idx_p1 + 7'd1;
            end
          end else begin
            if (!is_data_p0) begin
              frame_bad_p0 = 1'b1;
            end else begin
              cap_en_p0 = slot_p0.hit;
              idx_p0    = idx_p1 + 7'd1;
            end
          end
        end
        default: state_p0 = ST_HUNT;
      endcase

      if (frame_bad_p0) begin
        err_p0    = 1'b1;
        locked_p0 = 1'b0;
        state_p0  = ST_HUNT;
        idx_p0    = '0;
      end
    end else if (wd_expire_p0) begin
      wd_p0     = '0;
      tmo_p0    = 1'b1;
      locked_p0 = 1'b0;
      state_p0  = ST_HUNT;
      idx_p0    = '0;
    end
  end

  // ---- stage p1: registered control, strobes and published time ----
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_p1  <= ST_HUNT;
      idx_p1    <= '0;
      locked_p1 <= 1'b0;
      start_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
      tmo_p1    <= 1'b0;
      wd_p1     <= '0;
      time_p1   <= '0;
    end else begin
      state_p1  <= state_p0;
      idx_p1    <= idx_p0;
      locked_p1 <= locked_p0;
      start_p1  <= start_p0;
      vld_p1    <= vld_p0;
      err_p1    <= err_p0;
      tmo_p1    <= tmo_p0;
      wd_p1     <= wd_p0;
      if (pub_en_p0) time_p1 <= time_bcd_t'(shadow_p1);
    end
  end

  // Shadow word is datapath only; it is fully rewritten before any publish
  always_ff @(posedge Clk) begin
    if (cap_en_p0) shadow_p1[slot_p0.pos] <= cap_bit_p0;
  end

  assign bus.sec_bcd     = time_p1.sec;
  assign bus.min_bcd     = time_p1.min;
  assign bus.hour_bcd    = time_p1.hour;
  assign bus.day_bcd     = time_p1.day;
  assign bus.year_bcd    = time_p1.year;
  assign bus.frame_valid = vld_p1;
  assign bus.frame_start = start_p1;
  assign bus.frame_err   = err_p1;
  assign bus.timeout     = tmo_p1;
  assign bus.locked      = locked_p1;

endmodule
